// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
package regfile_pkg;

  // Clear-sweep sequencer states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefDepth = 64;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear-sweep sequencer: zeroes one entry per cycle from index 0 to DEPTH-1.
// Enters the sweep on reset and on every clear pulse; a clear mid-sweep restarts at 0.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH  = DefDepth,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_adr_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // Next-state: clear always (re)starts at index 0; sweep ends after the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clear_i) begin
      state_d = CLEAR;
      idx_d   = '0;
    end else if (state_q == CLEAR) begin
      if (idx_q == LastIdx) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // State and index registers; reset drops straight into a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Every CLEAR cycle writes zero to the current index.
  always_comb begin
    busy_o    = (state_q == CLEAR);
    clr_we_o  = (state_q == CLEAR);
    clr_adr_o = idx_q;
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with hardware clear sweep, write-to-read bypass and
// optional hardwired zero register.
// Build option: define REGFILE_SCOREBOARD_EN to add the per-entry pending scoreboard
// (reserveEnable/reserveAdr inputs, readPending output).
module register_file_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DefDataW,
  parameter  int unsigned DEPTH    = DefDepth,
  localparam int unsigned ADDR_W   = $clog2(DEPTH),
  parameter  int unsigned NUM_READ = 2,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [NUM_READ*ADDR_W-1:0] readAdr,
  output logic [NUM_READ*DATA_W-1:0] readData,
  input  logic [ADDR_W-1:0]          writeAdr,
  input  logic [DATA_W-1:0]          writeData,
  input  logic                       writeEnable,
  output logic                       busy
`ifdef REGFILE_SCOREBOARD_EN
  , input  logic                     reserveEnable
  , input  logic [ADDR_W-1:0]        reserveAdr
  , output logic [NUM_READ-1:0]      readPending
`endif
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_adr;
  logic              we_acc;
  logic [ADDR_W-1:0] rd_adr [NUM_READ];
  logic [NUM_READ-1:0] wr_hit;

  logic [DATA_W-1:0] mem_q [DEPTH];

  regfile_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_adr_o (clr_adr)
  );

  // Port write is accepted only when idle and not aimed at a hardwired zero entry.
  always_comb begin
    we_acc = writeEnable && !busy && !((ZERO_REG != 0) && (writeAdr == '0));
  end

  // Unpack read addresses and flag same-cycle write hits for the bypass path.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_adr[i] = readAdr[i*ADDR_W +: ADDR_W];
      wr_hit[i] = (BYPASS != 0) && we_acc && (writeAdr == rd_adr[i]);
    end
  end

  // Storage has no reset: the sweep zeroes it. Sweep and port writes never overlap
  // because port writes are blocked while busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_adr] <= '0;
    end else if (we_acc) begin
      mem_q[writeAdr] <= writeData;
    end
  end

  // Read mux: zero while sweeping or for entry 0, else bypass, else stored value.
  always_comb begin
    readData = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (busy || ((ZERO_REG != 0) && (rd_adr[i] == '0))) begin
        readData[i*DATA_W +: DATA_W] = '0;
      end else if (wr_hit[i]) begin
        readData[i*DATA_W +: DATA_W] = writeData;
      end else begin
        readData[i*DATA_W +: DATA_W] = mem_q[rd_adr[i]];
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pending_q, pending_d;
  logic             rsv_acc;

  // Reserve is ignored while sweeping and for a hardwired zero entry.
  always_comb begin
    rsv_acc = reserveEnable && !busy && !((ZERO_REG != 0) && (reserveAdr == '0));
  end

  // Pending update: sweep start wipes all; reserve beats a same-address write.
  always_comb begin
    pending_d = pending_q;
    if (clear) begin
      pending_d = '0;
    end else begin
      if (we_acc) begin
        pending_d[writeAdr] = 1'b0;
      end
      if (rsv_acc) begin
        pending_d[reserveAdr] = 1'b1;
      end
    end
  end

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A bypassed write satisfies the reader in the same cycle.
  always_comb begin
    readPending = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      readPending[i] = !busy && pending_q[rd_adr[i]] && !wr_hit[i];
    end
  end
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a default instance (ZERO_REG=1, BYPASS=1) and a
// second instance (ZERO_REG=0, BYPASS=0) driven by the same stimulus.
module tb_register_file_mp;

  localparam int unsigned AW = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [11:0]  radr = '0;
  logic [127:0] rd, rd_nb;
  logic [5:0]   wadr = '0;
  logic [63:0]  wdata = '0;
  logic         we = 1'b0;
  logic         busy, busy_nb;
`ifdef REGFILE_SCOREBOARD_EN
  logic         rsv_en = 1'b0;
  logic [5:0]   rsv_adr = '0;
  logic [1:0]   pend, pend_nb;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  register_file_mp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .readAdr     (radr),
    .readData    (rd),
    .writeAdr    (wadr),
    .writeData   (wdata),
    .writeEnable (we),
    .busy        (busy)
`ifdef REGFILE_SCOREBOARD_EN
    , .reserveEnable (rsv_en)
    , .reserveAdr    (rsv_adr)
    , .readPending   (pend)
`endif
  );

  register_file_mp #(
    .ZERO_REG (0),
    .BYPASS   (0)
  ) dut_nb (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .readAdr     (radr),
    .readData    (rd_nb),
    .writeAdr    (wadr),
    .writeData   (wdata),
    .writeEnable (we),
    .busy        (busy_nb)
`ifdef REGFILE_SCOREBOARD_EN
    , .reserveEnable (rsv_en)
    , .reserveAdr    (rsv_adr)
    , .readPending   (pend_nb)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int bad;

    // 1: reset held 3 cycles, then a 64-cycle sweep with all reads zero.
    radr = {6'd5, 6'd63};
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {127'b0, busy}, 128'd1);
    check("reset_busy_nb", {127'b0, busy_nb}, 128'd1);
    check("reset_rd", rd, 128'd0);
`ifdef REGFILE_SCOREBOARD_EN
    check("reset_pend", {126'b0, pend}, 128'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    bad = 0;
    while (busy && cnt < 200) begin
      if (rd !== 128'd0 || rd_nb !== 128'd0) bad++;
      @(negedge clk);
      cnt++;
    end
    check("sweep_len", 128'(cnt), 128'd64);
    check("sweep_rd_zero", 128'(bad), 128'd0);
    check("sweep_done_busy", {126'b0, busy, busy_nb}, 128'd0);

    // 2: write r5, read on both ports next cycle.
    we = 1'b1; wadr = 6'd5; wdata = 64'hDEAD_BEEF; radr = {6'd5, 6'd5};
    @(negedge clk);
    we = 1'b0;
    #1;
    check("r5_both", rd, {64'hDEAD_BEEF, 64'hDEAD_BEEF});
    check("r5_both_nb", rd_nb, {64'hDEAD_BEEF, 64'hDEAD_BEEF});

    // 3: bypass vs read-before-write on r7.
    we = 1'b1; wadr = 6'd7; wdata = 64'h1234; radr = {6'd7, 6'd7};
    #1;
    check("bypass_same", rd, {64'h1234, 64'h1234});
    check("nobypass_same", rd_nb, 128'd0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("nobypass_next", rd_nb, {64'h1234, 64'h1234});

    // 4: zero register and top entry.
    we = 1'b1; wadr = 6'd0; wdata = 64'hFF; radr = {6'd0, 6'd0};
    #1;
    check("r0_bypass_blocked", rd, 128'd0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("r0_zero", rd, 128'd0);
    check("r0_nb_written", rd_nb, {64'hFF, 64'hFF});
    we = 1'b1; wadr = 6'd63; wdata = 64'hFF;
    @(negedge clk);
    we = 1'b0; radr = {6'd5, 6'd63};
    #1;
    check("r63_r5", rd, {64'hDEAD_BEEF, 64'hFF});

    // 5: clear, restart at index 30, write during busy dropped.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clear_busy", {127'b0, busy}, 128'd1);
    repeat (30) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cnt = 0;
    bad = 0;
    radr = {6'd5, 6'd5};
    while (busy && cnt < 200) begin
      we = (cnt == 10); wadr = 6'd5; wdata = 64'h55;
      #1;
      if (rd !== 128'd0) bad++;
      @(negedge clk);
      cnt++;
    end
    we = 1'b0;
    check("restart_len", 128'(cnt), 128'd64);
    check("restart_rd_zero", 128'(bad), 128'd0);
    #1;
    check("busy_write_dropped", rd, 128'd0);
    radr = {6'd7, 6'd63};
    #1;
    check("swept_r7_r63", rd, 128'd0);

`ifdef REGFILE_SCOREBOARD_EN
    // 6: scoreboard reserve / write / simultaneous reserve+write on r9.
    rsv_en = 1'b1; rsv_adr = 6'd9;
    @(negedge clk);
    rsv_en = 1'b0; radr = {6'd9, 6'd9};
    #1;
    check("pend_set", {126'b0, pend}, 128'd3);
    we = 1'b1; wadr = 6'd9; wdata = 64'h99;
    #1;
    check("pend_bypass_clear", {126'b0, pend}, 128'd0);
    check("pend_nb_same", {126'b0, pend_nb}, 128'd3);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("pend_cleared", {124'b0, pend, pend_nb}, 128'd0);
    rsv_en = 1'b1; we = 1'b1;
    @(negedge clk);
    rsv_en = 1'b0; we = 1'b0;
    #1;
    check("pend_reserve_wins", {124'b0, pend, pend_nb}, 128'hF);
    rsv_en = 1'b1; rsv_adr = 6'd0;
    @(negedge clk);
    rsv_en = 1'b0; radr = {6'd0, 6'd0};
    #1;
    check("pend_r0", {124'b0, pend, pend_nb}, 128'h3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
